cpu_bus_resp: RTL and testbench

CPU_BUS_RESP -- requirements
Module: cpu_bus_resp

---
 rtl/cpu_bus_pkg.sv | 40 ++++
 rtl/ram_2k.sv | 24 ++
 rtl/cpu_bus_resp.sv | 151 +++++++++++++++
 tb/tb_cpu_bus_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus responder: region decode and OAM DMA states.

package cpu_bus_pkg;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaAlign,
        DmaRd,
        DmaWr
    } dma_state_e;

    typedef enum logic [2:0] {
        RegionRam,
        RegionPpu,
        RegionOamdma,
        RegionRom,
        RegionNone
    } region_e;

    localparam logic [15:0] OAMDMA_ADDR     = 16'h4014;
    localparam logic [2:0]  OAM_DATA_REG    = 3'd4;
    localparam logic [15:0] RAM_MIRROR_MASK = 16'h07FF;

    function automatic region_e decode_region(input logic [15:0] addr);
        region_e region;
        if (addr[15]) begin
            region = RegionRom;
        end else if (addr[15:13] == 3'b000) begin
            region = RegionRam;
        end else if (addr[15:13] == 3'b001) begin
            region = RegionPpu;
        end else if (addr == OAMDMA_ADDR) begin
            region = RegionOamdma;
        end else begin
            region = RegionNone;
        end
        return region;
    endfunction

endpackage

// File: rtl/ram_2k.sv
// Synchronous single-port work RAM, write-first: a write also presents the new byte on rdata.

module ram_2k #(
    parameter int unsigned RAM_AW = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [1 << RAM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_bus_resp.sv
// CPU bus responder: address decode, one-cycle read path, PPU strobes and the OAM DMA engine
// that halts the CPU while copying a 256-byte page into the PPU OAM data register.

module cpu_bus_resp
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_AW = 11,
    parameter int unsigned ROM_AW = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_write,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rdy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [2:0]        ppu_reg,
    output logic              ppu_re,
    output logic              ppu_we,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic       align_odd_q, align_odd_d;
    logic       parity_q;

    region_e    rd_region_q;
    logic       cpu_rd_q;
    logic [7:0] hold_q;

    logic [15:0]       bus_addr;
    region_e           bus_region;
    logic              cpu_rd, cpu_wr;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic [7:0]        rd_mux;

    assign cpu_rdy = (state_q == DmaIdle);
    assign cpu_rd  = cpu_rdy & ~cpu_write;
    assign cpu_wr  = cpu_rdy & cpu_write;

    // The DMA engine borrows the bus only in its read cycle; otherwise the CPU drives it.
    assign bus_addr   = (state_q == DmaRd) ? {page_q, cnt_q} : cpu_addr;
    assign bus_region = decode_region(bus_addr);

    assign ram_we   = cpu_wr & (bus_region == RegionRam);
    assign ram_addr = RAM_AW'(bus_addr & RAM_MIRROR_MASK);
    assign rom_addr = bus_addr[ROM_AW-1:0];

    ram_2k #(
        .RAM_AW(RAM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(cpu_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        rd_mux = 8'h00;
        unique case (rd_region_q)
            RegionRam: rd_mux = ram_rdata;
            RegionPpu: rd_mux = ppu_rdata;
            RegionRom: rd_mux = rom_data;
            default:   rd_mux = 8'h00;
        endcase
    end

    // Fresh data only after a CPU read cycle; otherwise the last value is held.
    assign cpu_rdata = cpu_rd_q ? rd_mux : hold_q;

    always_comb begin
        ppu_re    = 1'b0;
        ppu_we    = 1'b0;
        ppu_reg   = bus_addr[2:0];
        ppu_wdata = cpu_wdata;
        if (state_q == DmaWr) begin
            ppu_we    = 1'b1;
            ppu_reg   = OAM_DATA_REG;
            ppu_wdata = rd_mux;
        end else if (bus_region == RegionPpu) begin
            ppu_re = (state_q == DmaRd) | cpu_rd;
            ppu_we = cpu_wr;
        end
        if (rst) begin
            ppu_re = 1'b0;
            ppu_we = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        cnt_d       = cnt_q;
        align_odd_d = align_odd_q;
        unique case (state_q)
            DmaIdle: begin
                if (cpu_wr && bus_region == RegionOamdma) begin
                    state_d     = DmaAlign;
                    page_d      = cpu_wdata;
                    cnt_d       = 8'h00;
                    align_odd_d = parity_q;
                end
            end
            DmaAlign: begin
                // An odd-cycle trigger spends one extra cycle here.
                if (align_odd_q) begin
                    align_odd_d = 1'b0;
                end else begin
                    state_d = DmaRd;
                end
            end
            DmaRd: state_d = DmaWr;
            DmaWr: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q == 8'hFF) ? DmaIdle : DmaRd;
            end
            default: state_d = DmaIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DmaIdle;
            page_q      <= 8'h00;
            cnt_q       <= 8'h00;
            align_odd_q <= 1'b0;
            parity_q    <= 1'b0;
            rd_region_q <= RegionNone;
            cpu_rd_q    <= 1'b0;
            hold_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            cnt_q       <= cnt_d;
            align_odd_q <= align_odd_d;
            parity_q    <= ~parity_q;
            rd_region_q <= bus_region;
            cpu_rd_q    <= cpu_rd;
            hold_q      <= cpu_rdata;
        end
    end

endmodule

// File: tb/tb_cpu_bus_resp.sv
// Directed bench for cpu_bus_resp with a read-data scoreboard and an OAM DMA byte scoreboard.

module tb_cpu_bus_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [2:0]  ppu_reg;
    logic        ppu_re;
    logic        ppu_we;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_m [2048];
    logic [7:0] exp_q [$];
    logic [7:0] dma_q [$];
    logic [7:0] held;
    bit         pend;
    logic       par;

    always #5 clk = ~clk;

    cpu_bus_resp #(
        .RAM_AW(11),
        .ROM_AW(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_rdy  (cpu_rdy),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ppu_reg  (ppu_reg),
        .ppu_re   (ppu_re),
        .ppu_we   (ppu_we),
        .ppu_wdata(ppu_wdata),
        .ppu_rdata(ppu_rdata)
    );

    // Registered ROM and PPU models: data valid the cycle after address/strobe.
    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'h5A;
    always @(posedge clk) if (ppu_re) ppu_rdata <= {5'b11000, ppu_reg};

    always @(posedge clk or posedge rst) begin
        if (rst) par <= 1'b0;
        else     par <= ~par;
    end

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        if (a[15])               return a[7:0] ^ 8'h5A;
        else if (a < 16'h2000)   return ram_m[a[10:0]];
        else if (a < 16'h4000)   return {5'b11000, a[2:0]};
        else                     return 8'h00;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One CPU bus cycle: drive after the edge, check strobes and the previous read at negedge.
    task automatic step(input logic [15:0] a, input bit wr, input logic [7:0] d);
        bit is_ppu;
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_write = wr;
        cpu_wdata = d;
        is_ppu    = (a[15:13] == 3'b001);
        if (!wr) exp_q.push_back(exp_read(a));
        else if (a < 16'h2000) ram_m[a[10:0]] = d;
        @(negedge clk);
        if (pend) begin
            held = exp_q.pop_front();
            chk8("rdata", cpu_rdata, held);
        end else begin
            chk8("rdata_hold", cpu_rdata, held);
        end
        chk1("rdy", cpu_rdy, 1'b1);
        chk1("ppu_we", ppu_we, wr && is_ppu);
        chk1("ppu_re", ppu_re, !wr && is_ppu);
        if (is_ppu) chk8("ppu_reg", {5'b0, ppu_reg}, {5'b0, a[2:0]});
        if (wr && is_ppu) chk8("ppu_wdata", ppu_wdata, d);
        pend = !wr;
    endtask

    task automatic run_dma(input logic [7:0] page, input bit odd, input int abort_at);
        int low = 0;
        int nwe = 0;
        logic [7:0] e;
        // Next cycle's parity is ~par; insert a filler read if that is the wrong one.
        if (par == odd) step(16'h5000, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) dma_q.push_back(exp_read({page, 8'(i)}));
        step(16'h4014, 1'b1, page);
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            cpu_addr  = 16'h0000;
            cpu_write = 1'b1;
            cpu_wdata = 8'hEE;
            @(negedge clk);
            if (cpu_rdy) begin
                cpu_write = 1'b0;
                cpu_addr  = 16'h5000;
                exp_q.push_back(8'h00);
                pend = 1'b1;
                break;
            end
            low++;
            chk8("dma_rdata_hold", cpu_rdata, held);
            if (ppu_we) begin
                nwe++;
                chk8("dma_reg", {5'b0, ppu_reg}, 8'h04);
                if (dma_q.size() == 0) begin
                    chkn("dma_extra_we", nwe, 256);
                end else begin
                    e = dma_q.pop_front();
                    chk8("dma_data", ppu_wdata, e);
                end
            end
            if (abort_at > 0 && nwe == abort_at) begin
                cpu_write = 1'b0;
                rst = 1'b1;
                #1;
                chk1("abort_we", ppu_we, 1'b0);
                chk1("abort_rdy", cpu_rdy, 1'b1);
                chk8("abort_rdata", cpu_rdata, 8'h00);
                @(negedge clk);
                chk1("abort_we2", ppu_we, 1'b0);
                chk1("abort_rdy2", cpu_rdy, 1'b1);
                cpu_addr = 16'h5000;
                rst = 1'b0;
                exp_q.delete();
                dma_q.delete();
                exp_q.push_back(8'h00);
                held = 8'h00;
                pend = 1'b1;
                return;
            end
        end
        cpu_write = 1'b0;
        chkn("halt_cycles", low, odd ? 514 : 513);
        chkn("dma_bytes", nwe, 256);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cpu_addr  = 16'h2000;
        cpu_write = 1'b0;
        cpu_wdata = 8'h00;
        held      = 8'h00;
        pend      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_rdy", cpu_rdy, 1'b1);
        chk8("rst_rdata", cpu_rdata, 8'h00);
        chk1("rst_we", ppu_we, 1'b0);
        chk1("rst_re", ppu_re, 1'b0);
        cpu_addr = 16'h5000;
        rst      = 1'b0;
        exp_q.push_back(8'h00);
        pend = 1'b1;

        step(16'h0001, 1'b1, 8'hA5);
        step(16'h1801, 1'b0, 8'h00);
        step(16'h0000, 1'b1, 8'h11);
        step(16'h3FFE, 1'b1, 8'h3C);
        step(16'h8000, 1'b1, 8'h77);
        step(16'h8000, 1'b0, 8'h00);
        step(16'h0000, 1'b0, 8'h00);
        step(16'h2002, 1'b0, 8'h00);
        step(16'h5000, 1'b0, 8'h00);
        step(16'h0801, 1'b0, 8'h00);
        step(16'h4014, 1'b0, 8'h00);
        step(16'h0801, 1'b0, 8'h00);
        step(16'h5000, 1'b1, 8'h99);
        step(16'h2007, 1'b0, 8'h00);

        for (int i = 0; i < 256; i++) step({8'h02, 8'(i)}, 1'b1, 8'(i));
        run_dma(8'h02, 1'b0, 0);
        step(16'h0000, 1'b0, 8'h00);
        run_dma(8'h02, 1'b1, 0);
        run_dma(8'h80, 1'b1, 0);
        run_dma(8'h02, 1'b0, 100);

        for (int i = 0; i < 8; i++) step(16'h5000, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) step({8'h02, 8'(i)}, 1'b1, ~8'(i));
        run_dma(8'h02, 1'b0, 0);
        step(16'h0205, 1'b0, 8'h00);
        step(16'h5000, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
